dsc_mul_engine: RTL and testbench

- Parametrised deterministic-stochastic-computing (DSC) multiplier using clock division: NUM_INPUTS unary streams are ANDed and their 1s are counted.
- Successor to the fixed core: arbitrary channel count, start/valid/ready handshake, exact early finish, optional hardware cycle budget (truncated mode) with a flag.
- Sits between operand staging and the result/MAE logging path.

---
 rtl/dsc_pkg.sv | 23 ++
 rtl/dsc_odometer.sv | 52 +++++
 rtl/dsc_mul_engine.sv | 150 +++++++++++++++
 tb/tb_dsc_mul_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared types and width helpers for the deterministic-stochastic multiplier.
package dsc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dsc_state_t;

  // Product / accumulator width: K operands of W bits multiply into K*W bits.
  function automatic int pw_of(input int k, input int w);
    return k * w;
  endfunction

  // Cycle counter needs one extra bit to hold the full 2^(K*W) span.
  function automatic int cw_of(input int k, input int w);
    return k * w + 1;
  endfunction

  // Fewest RUN cycles any operation can take (a zero operand skips RUN).
  localparam int MIN_CYC_DSC = 0;

endpackage

// File: rtl/dsc_odometer.sv
// K chained W-bit counters; channel i steps when every lower channel wraps.
module dsc_odometer #(
  parameter int W = 8,
  parameter int K = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           advance,
  input  logic [K*W-1:0] x,
  output logic [K-1:0]   lt,
  output logic           carry_last,
  output logic [W-1:0]   count_last
);

  logic [W-1:0] c [K];
  logic [K-1:0] carry;

  always_comb begin
    carry    = '0;
    carry[0] = advance;
    for (int i = 1; i < K; i++) begin
      carry[i] = carry[i-1] && (c[i-1] == {W{1'b1}});
    end
  end

  always_comb begin
    lt = '0;
    for (int i = 0; i < K; i++) begin
      lt[i] = (c[i] < x[i*W +: W]);
    end
  end

  // The top channel never reaches its wrap: the run stops once it equals x_{K-1}.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < K; i++) begin
        c[i] <= '0;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        if (carry[i]) begin
          c[i] <= c[i] + W'(1);
        end
      end
    end
  end

  assign carry_last = carry[K-1];
  assign count_last = c[K-1];

endmodule

// File: rtl/dsc_mul_engine.sv
// DSC multiplier: ANDs K unary streams produced by an odometer and counts the 1s.
// Handshake: start is taken only while in_ready (IDLE); a result is held with
// out_valid until out_ready is seen high on a clock edge.
module dsc_mul_engine
  import dsc_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_INPUTS = 2,
  localparam int PW         = pw_of(NUM_INPUTS, DATA_WIDTH),
  localparam int CW         = cw_of(NUM_INPUTS, DATA_WIDTH)
) (
  input  logic                             gclk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_in,
  input  logic                             limit_en,
  input  logic [CW-1:0]                    cycle_limit,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PW-1:0]                    bin_data_out,
  output logic [CW-1:0]                    cycle_count,
  output logic                             truncated,
  output logic [1:0]                       fsm_state
);

  localparam int W = DATA_WIDTH;
  localparam int K = NUM_INPUTS;

  dsc_state_t state, state_next;

  logic [K*W-1:0] x_q;
  logic           limit_en_q;
  logic [CW-1:0]  limit_q;
  logic [PW-1:0]  acc;
  logic [CW-1:0]  cyc;
  logic           trunc_q;
  logic           valid_q;

  logic           load;
  logic           advance;
  logic           any_zero;
  logic           exact;
  logic           budget;
  logic [K-1:0]   lt;
  logic           carry_last;
  logic [W-1:0]   count_last;
  logic [CW-1:0]  cyc_next;
  logic [W:0]     last_next;

  dsc_odometer #(
    .W (W),
    .K (K)
  ) u_odometer (
    .clk        (gclk),
    .rst_n      (rst_n),
    .clear      (load),
    .advance    (advance),
    .x          (x_q),
    .lt         (lt),
    .carry_last (carry_last),
    .count_last (count_last)
  );

  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (bin_data_in[i*W +: W] == '0) begin
        any_zero = 1'b1;
      end
    end
  end

  // Both finish conditions look at post-update values so the final cycle counts.
  assign cyc_next  = cyc + CW'(1);
  assign last_next = {1'b0, count_last} + (W+1)'(carry_last);
  assign exact     = (last_next == {1'b0, x_q[(K-1)*W +: W]});
  assign budget    = limit_en_q && (limit_q != '0) && (cyc_next == limit_q);

  always_ff @(posedge gclk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = any_zero ? DONE : RUN;
        end
      end
      RUN: begin
        advance = 1'b1;
        if (exact || budget) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (!rst_n) begin
      x_q        <= '0;
      limit_en_q <= 1'b0;
      limit_q    <= '0;
      acc        <= '0;
      cyc        <= '0;
      trunc_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= (state_next == DONE);
      if (load) begin
        x_q        <= bin_data_in;
        limit_en_q <= limit_en;
        limit_q    <= cycle_limit;
        acc        <= '0;
        cyc        <= '0;
        trunc_q    <= 1'b0;
      end else if (advance) begin
        acc <= acc + PW'(&lt);
        cyc <= cyc_next;
        // An exact finish on the budget cycle is a complete product, not a cut one.
        if (budget && !exact) begin
          trunc_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = valid_q;
  assign bin_data_out = acc;
  assign cycle_count  = cyc;
  assign truncated    = trunc_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_dsc_mul_engine.sv
// Directed bench for dsc_mul_engine (K=2/W=4 main instance, K=3/W=3 second instance).
module tb_dsc_mul_engine;
  import dsc_pkg::*;

  logic       gclk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start = 1'b0;
  logic       in_ready;
  logic [7:0] bin_data_in = '0;
  logic       limit_en = 1'b0;
  logic [8:0] cycle_limit = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] bin_data_out;
  logic [8:0] cycle_count;
  logic       truncated;
  logic [1:0] fsm_state;

  logic       start3 = 1'b0;
  logic       in_ready3;
  logic [8:0] din3 = '0;
  logic       limit_en3 = 1'b0;
  logic [9:0] cycle_limit3 = '0;
  logic       out_valid3;
  logic       out_ready3 = 1'b0;
  logic [8:0] bin3;
  logic [9:0] cyc3;
  logic       trunc3;
  logic [1:0] fsm3;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] acc;
    logic [8:0] cyc;
    logic       trunc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    longint acc;
    longint cyc;
    bit     trunc;
  } res_t;

  always #5 gclk = ~gclk;

  dsc_mul_engine #(.DATA_WIDTH(4), .NUM_INPUTS(2)) dut (
    .gclk         (gclk),
    .rst_n        (rst_n),
    .start        (start),
    .in_ready     (in_ready),
    .bin_data_in  (bin_data_in),
    .limit_en     (limit_en),
    .cycle_limit  (cycle_limit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .bin_data_out (bin_data_out),
    .cycle_count  (cycle_count),
    .truncated    (truncated),
    .fsm_state    (fsm_state)
  );

  dsc_mul_engine #(.DATA_WIDTH(3), .NUM_INPUTS(3)) dut3 (
    .gclk         (gclk),
    .rst_n        (rst_n),
    .start        (start3),
    .in_ready     (in_ready3),
    .bin_data_in  (din3),
    .limit_en     (limit_en3),
    .cycle_limit  (cycle_limit3),
    .out_valid    (out_valid3),
    .out_ready    (out_ready3),
    .bin_data_out (bin3),
    .cycle_count  (cyc3),
    .truncated    (trunc3),
    .fsm_state    (fsm3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Cycle t of the run visits digit i = (t >> i*W) mod 2^W; the top digit is t >> (K-1)*W.
  function automatic res_t model(input int k, input int w, input int xs[4],
                                 input bit len, input longint lim);
    res_t   r;
    longint exact_n;
    longint n;
    longint ci;
    bit     one;
    r = '{0, 0, 0};
    for (int i = 0; i < k; i++) begin
      if (xs[i] == 0) begin
        r.cyc = MIN_CYC_DSC;
        return r;
      end
    end
    exact_n = longint'(xs[k-1]) << ((k - 1) * w);
    n = exact_n;
    if (len && lim != 0 && lim < exact_n) begin
      n = lim;
      r.trunc = 1'b1;
    end
    for (longint t = 0; t < n; t++) begin
      one = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (i == k - 1) ci = t >> ((k - 1) * w);
        else            ci = (t >> (i * w)) % (longint'(1) << w);
        if (ci >= xs[i]) one = 1'b0;
      end
      if (one) r.acc++;
    end
    r.cyc = n;
    return r;
  endfunction

  // Scoreboard: every cycle a result is presented it must match the head entry.
  always @(negedge gclk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", out_valid, 0);
      end else begin
        chk("sb_acc", bin_data_out, exp_q[0].acc);
        chk("sb_cyc", cycle_count, exp_q[0].cyc);
        chk("sb_trunc", truncated, exp_q[0].trunc);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input int x0, input int x1, input bit len, input int lim,
                        input int hold, input int lit_acc, input int lit_cyc, input bit lit_tr);
    res_t m;
    int   xs[4];
    int   n;
    exp_t e;
    xs = '{x0, x1, 0, 0};
    m = model(2, 4, xs, len, lim);
    chk("model_acc", m.acc, lit_acc);
    chk("model_cyc", m.cyc, lit_cyc);
    chk("model_trunc", m.trunc, lit_tr);
    chk("in_ready_idle", in_ready, 1);
    e.acc   = m.acc[7:0];
    e.cyc   = m.cyc[8:0];
    e.trunc = m.trunc;
    exp_q.push_back(e);
    start       = 1'b1;
    bin_data_in = {4'(x1), 4'(x0)};
    limit_en    = len;
    cycle_limit = 9'(lim);
    @(posedge gclk); #1;
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 1000) begin
      @(posedge gclk); #1;
      n++;
    end
    chk("latency", n, m.cyc);
    chk("dut_acc", bin_data_out, lit_acc);
    chk("dut_cyc", cycle_count, lit_cyc);
    chk("dut_trunc", truncated, lit_tr);
    for (int i = 0; i < hold; i++) begin
      start       = ~i[0];
      bin_data_in = 8'h11;
      chk("in_ready_done", in_ready, 0);
      @(posedge gclk); #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge gclk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t m;
    int   n;
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_out", bin_data_out, 0);
    chk("rst_cyc", cycle_count, 0);
    chk("rst_trunc", truncated, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state", fsm_state, 0);
    rst_n = 1'b1;
    @(posedge gclk); #1;

    run_op(3, 5, 0, 0, 0, 15, 80, 0);
    run_op(3, 5, 1, 40, 5, 9, 40, 1);
    run_op(3, 5, 1, 80, 0, 15, 80, 0);
    run_op(3, 5, 1, 0, 0, 15, 80, 0);
    run_op(15, 15, 0, 0, 0, 225, 240, 0);
    run_op(7, 0, 0, 0, 5, 0, 0, 0);
    run_op(0, 9, 1, 3, 0, 0, 0, 0);

    // Abort an operation with a one-edge reset at RUN cycle 30.
    start       = 1'b1;
    bin_data_in = {4'd5, 4'd3};
    limit_en    = 1'b0;
    @(posedge gclk); #1;
    start = 1'b0;
    repeat (29) @(posedge gclk);
    #1;
    chk("mid_run_cyc", cycle_count, 29);
    rst_n = 1'b0;
    @(posedge gclk); #1;
    rst_n = 1'b1;
    chk("abort_valid", out_valid, 0);
    chk("abort_out", bin_data_out, 0);
    chk("abort_cyc", cycle_count, 0);
    chk("abort_trunc", truncated, 0);
    chk("abort_state", fsm_state, 0);
    chk("abort_in_ready", in_ready, 1);

    run_op(2, 2, 0, 0, 0, 4, 32, 0);
    run_op(2, 2, 1, 100, 0, 4, 32, 0);

    // Three-channel instance: x = (2,3,4).
    m = model(3, 3, '{2, 3, 4, 0}, 0, 0);
    chk("model3_acc", m.acc, 24);
    chk("model3_cyc", m.cyc, 256);
    chk("k3_in_ready", in_ready3, 1);
    start3 = 1'b1;
    din3   = {3'd4, 3'd3, 3'd2};
    @(posedge gclk); #1;
    start3 = 1'b0;
    n = 0;
    while (!out_valid3 && n < 1000) begin
      @(posedge gclk); #1;
      n++;
    end
    chk("k3_latency", n, m.cyc);
    chk("k3_acc", bin3, m.acc);
    chk("k3_cyc", cyc3, m.cyc);
    chk("k3_trunc", trunc3, m.trunc);
    out_ready3 = 1'b1;
    @(posedge gclk); #1;
    out_ready3 = 1'b0;
    chk("k3_valid_drop", out_valid3, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
